ysyx_23060042_core_ctrl: RTL
============================

# ysyx_23060042_core_ctrl

Multi-cycle control FSM for the NPC core. It sequences instruction fetch, the decoder, execute, load/store and register/PC writeback of one RV32I instruction at a time. It classifies the instruction from the decoder's `opcode`/`func3`/`i_imm` fields and drives every datapath enable. It sits between the fetch port, the decoder/EXU datapath and the LSU port.

## Interface
Parameters:
- `CNT_W`, 64, width of performance counters

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  7  decoder opcode field, `inst[6:0]`
- `func3`  in  3  decoder func3 field
- `i_imm`  in  12  decoder I-immediate, used for SYSTEM decode
- `br_taken`  in  1  EXU branch-compare result, valid in EXEC
- `ifetch_req_valid`  out  1  fetch request
- `ifetch_req_ready`  in  1  fetch request accepted
- `ifetch_resp_valid`  in  1  instruction word valid
- `ir_we`  out  1  latch fetched word into the instruction register
- `lsu_req_valid`  out  1  LSU request
- `lsu_req_we`  out  1  1 = store, 0 = load
- `lsu_req_ready`  in  1  LSU request accepted
- `lsu_resp_valid`  in  1  load data / store acknowledge
- `rf_we`  out  1  register-file write enable
- `pc_we`  out  1  PC update enable
- `pc_sel`  out  1  0 = PC+4, 1 = target (branch/jump)
- `halt`  out  1  core halted (sticky)
- `halt_err`  out  1  halt caused by an illegal instruction
- `cycle_cnt`  out  CNT_W  cycles counted
- `instret_cnt`  out  CNT_W  instructions retired

## Operation
- Instruction classes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, SYSTEM 1110011.
- Any other opcode is ILLEGAL.
- EBREAK is SYSTEM with func3=0 and i_imm=12'h001. Any other SYSTEM encoding is ILLEGAL.
- States: FETCH, WAIT_I, DECODE, EXEC, MEM, WAIT_M, WB, HALT.
- FETCH: `ifetch_req_valid`=1. Go to WAIT_I on `ifetch_req_ready`.
- WAIT_I: on `ifetch_resp_valid`, pulse `ir_we` and go to DECODE.
- DECODE:
  - EBREAK → HALT with `halt_err`=0.
  - ILLEGAL → HALT with `halt_err`=1.
  - Otherwise → EXEC.
- EXEC: register `take_target` = JAL | JALR | (BRANCH & `br_taken`). LOAD/STORE → MEM; else → WB.
- MEM: `lsu_req_valid`=1, `lsu_req_we`=(STORE). Hold until `lsu_req_ready`, then go to WAIT_M.
- WAIT_M: on `lsu_resp_valid` go to WB.
- WB:
  - `pc_we`=1 and `pc_sel`=`take_target`.
  - `rf_we`=1 unless BRANCH or STORE.
  - Next state FETCH.
- HALT: absorbing state; `halt`=1 until `rst`. No further requests or enables.
- Request valids stay high and stable until accepted. Responses arriving outside WAIT_I/WAIT_M are ignored.

## Timing
- Reset (synchronous): state=FETCH, `take_target`=0, counters=0, `halt`=`halt_err`=0.
- First cycle after reset, `ifetch_req_valid`=1. All other outputs are 0 during reset.
- `ir_we`, `rf_we`, `pc_we` are single-cycle pulses.
- `pc_sel` is only meaningful while `pc_we`=1; otherwise it is 0.
- With zero-wait memory (ready in the request cycle, response in the next cycle):
  - ALU/branch/jump instruction: 5 cycles (FETCH, WAIT_I, DECODE, EXEC, WB).
  - Load/store instruction: 7 cycles.
- Each ready/response stall adds one cycle per stalled cycle.
- Reset mid-instruction abandons it. Fetch and LSU ports share the same `rst` and must drop outstanding transactions.
- Reset asserted in HALT returns the FSM to FETCH.

## Configuration
- `YSYX_23060042_PERF_EN` defined:
  - `cycle_cnt` increments every non-reset cycle while not in HALT.
  - `instret_cnt` increments on each WB cycle and on the cycle entering HALT via EBREAK.
  - Both counters wrap modulo 2^CNT_W.
- Undefined: both counter ports exist and are tied to 0; no counter flops are generated.

## Structure
- Package `ysyx_23060042_pkg`: opcode localparams, `ctrl_state_t` enum, `inst_class_t` enum (ALU, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, EBREAK, ILLEGAL).
- Sub-module `ysyx_23060042_opclass`: combinational {opcode, func3, i_imm} → `inst_class_t`. FSM and counters live in the top module.

## Test plan
- OP-IMM, zero-wait memory → `ir_we` in cycle 2, `rf_we`=`pc_we`=1 and `pc_sel`=0 in cycle 5, FETCH again in cycle 6.
- LOAD with `lsu_req_ready` low 3 cycles and response 2 cycles later → `lsu_req_valid` held 4 cycles, `rf_we` after response; STORE gives `rf_we`=0.
- BRANCH with `br_taken`=1 then `br_taken`=0 → `pc_sel`=1 then 0 in WB; `rf_we`=0 both times.
- opcode 7'h73, func3 0, i_imm 1 → `halt`=1, `halt_err`=0, no `pc_we`; opcode 7'h7F → `halt_err`=1; both stay halted for 20 cycles.
- `rst` asserted during WAIT_M → next cycle FETCH with outputs cleared; late `lsu_resp_valid` ignored.
- With `YSYX_23060042_PERF_EN`: 3 OP-IMM + EBREAK → `instret_cnt`=4 and `cycle_cnt`=18 frozen; without the macro both counters read 0.

Source files
------------

// File: rtl/ysyx_23060042_core_ctrl_pkg.sv
// Shared opcode constants, FSM state and instruction-class types for the
// multi-cycle NPC control path.
package ysyx_23060042_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [11:0] IMM_EBREAK = 12'h001;

    typedef enum logic [2:0] {
        ST_FETCH, ST_WAIT_I, ST_DECODE, ST_EXEC,
        ST_MEM, ST_WAIT_M, ST_WB, ST_HALT
    } ctrl_state_t;

    typedef enum logic [3:0] {
        CL_ALU, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR,
        CL_BRANCH, CL_LOAD, CL_STORE, CL_EBREAK, CL_ILLEGAL
    } inst_class_t;

endpackage

// File: rtl/ysyx_23060042_core_ctrl_if.sv
// Fetch and LSU valid/ready handshakes between the control FSM (master)
// and the memory side (slave).
interface ysyx_23060042_core_ctrl_if;
    logic ifetch_req_valid;
    logic ifetch_req_ready;
    logic ifetch_resp_valid;
    logic lsu_req_valid;
    logic lsu_req_we;
    logic lsu_req_ready;
    logic lsu_resp_valid;

    modport master (
        output ifetch_req_valid,
        input  ifetch_req_ready,
        input  ifetch_resp_valid,
        output lsu_req_valid,
        output lsu_req_we,
        input  lsu_req_ready,
        input  lsu_resp_valid
    );

    modport slave (
        input  ifetch_req_valid,
        output ifetch_req_ready,
        output ifetch_resp_valid,
        input  lsu_req_valid,
        input  lsu_req_we,
        output lsu_req_ready,
        output lsu_resp_valid
    );
endinterface

// File: rtl/ysyx_23060042_core_ctrl_opclass.sv
// Combinational RV32I instruction classifier: {opcode, func3, i_imm} -> class.
module ysyx_23060042_opclass
    import ysyx_23060042_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_func3,
    input  logic [11:0] i_imm,
    output inst_class_t o_class
);

    always_comb begin
        case (i_opcode)
            OPC_LUI:    o_class = CL_LUI;
            OPC_AUIPC:  o_class = CL_AUIPC;
            OPC_JAL:    o_class = CL_JAL;
            OPC_JALR:   o_class = CL_JALR;
            OPC_BRANCH: o_class = CL_BRANCH;
            OPC_LOAD:   o_class = CL_LOAD;
            OPC_STORE:  o_class = CL_STORE;
            OPC_OP_IMM: o_class = CL_ALU;
            OPC_OP:     o_class = CL_ALU;
            // Only EBREAK is supported from the SYSTEM space.
            OPC_SYSTEM: o_class = (i_func3 == 3'd0 && i_imm == IMM_EBREAK) ? CL_EBREAK : CL_ILLEGAL;
            default:    o_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/ysyx_23060042_core_ctrl.sv
// Multi-cycle control FSM of the NPC core, one RV32I instruction at a time.
// Define YSYX_23060042_PERF_EN to build the cycle/instret performance counters.
module ysyx_23060042_core_ctrl
    import ysyx_23060042_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic [11:0]          i_imm,
    input  logic                 br_taken,
    ysyx_23060042_core_ctrl_if.master bus,
    output logic                 ir_we,
    output logic                 rf_we,
    output logic                 pc_we,
    output logic                 pc_sel,
    output logic                 halt,
    output logic                 halt_err,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instret_cnt
);

    ctrl_state_t r_state;
    ctrl_state_t w_next;
    inst_class_t w_class;
    logic        r_take_target;
    logic        r_halt_err;
    logic        w_take_target;
    logic        w_ifetch_req;
    logic        w_lsu_req;
    logic        w_ir_we;
    logic        w_rf_we;
    logic        w_pc_we;
    logic        w_pc_sel;

    ysyx_23060042_opclass u_opclass (
        .i_opcode (opcode),
        .i_func3  (func3),
        .i_imm    (i_imm),
        .o_class  (w_class)
    );

    assign w_take_target = (w_class == CL_JAL) || (w_class == CL_JALR) ||
                           ((w_class == CL_BRANCH) && br_taken);

    // NOTE: state flops use non-blocking assignments so every register samples
    // pre-edge values regardless of the order the simulator evaluates blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            r_take_target <= 1'b0;
            r_halt_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_EXEC)
                r_take_target <= w_take_target;
            if (r_state == ST_DECODE && w_class == CL_ILLEGAL)
                r_halt_err <= 1'b1;
        end
    end

    // NOTE: every output of this block is given a default first; a signal left
    // unassigned on some path would otherwise infer a latch.
    always_comb begin
        w_next       = r_state;
        w_ifetch_req = 1'b0;
        w_lsu_req    = 1'b0;
        w_ir_we      = 1'b0;
        w_rf_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_sel     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_ifetch_req = 1'b1;
                if (bus.ifetch_req_ready) w_next = ST_WAIT_I;
            end
            ST_WAIT_I: begin
                if (bus.ifetch_resp_valid) begin
                    w_ir_we = 1'b1;
                    w_next  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_class == CL_EBREAK || w_class == CL_ILLEGAL) w_next = ST_HALT;
                else                                              w_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_class == CL_LOAD || w_class == CL_STORE) w_next = ST_MEM;
                else                                          w_next = ST_WB;
            end
            ST_MEM: begin
                w_lsu_req = 1'b1;
                if (bus.lsu_req_ready) w_next = ST_WAIT_M;
            end
            ST_WAIT_M: begin
                if (bus.lsu_resp_valid) w_next = ST_WB;
            end
            ST_WB: begin
                w_pc_we  = 1'b1;
                w_pc_sel = r_take_target;
                w_rf_we  = !(w_class == CL_BRANCH || w_class == CL_STORE);
                w_next   = ST_FETCH;
            end
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_FETCH;
        endcase
    end

    // Outputs are forced low while reset is held, whatever the current state.
    assign bus.ifetch_req_valid = w_ifetch_req & ~rst;
    assign bus.lsu_req_valid    = w_lsu_req & ~rst;
    assign bus.lsu_req_we       = w_lsu_req & (w_class == CL_STORE) & ~rst;
    assign ir_we                = w_ir_we & ~rst;
    assign rf_we                = w_rf_we & ~rst;
    assign pc_we                = w_pc_we & ~rst;
    assign pc_sel               = w_pc_sel & ~rst;
    assign halt                 = (r_state == ST_HALT) & ~rst;
    assign halt_err             = r_halt_err & ~rst;

`ifdef YSYX_23060042_PERF_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;
    logic             w_retire;

    assign w_retire = (r_state == ST_WB) || (r_state == ST_DECODE && w_class == CL_EBREAK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != ST_HALT) r_cycle_cnt   <= r_cycle_cnt + CNT_W'(1);
            if (w_retire)           r_instret_cnt <= r_instret_cnt + CNT_W'(1);
        end
    end

    assign cycle_cnt   = rst ? '0 : r_cycle_cnt;
    assign instret_cnt = rst ? '0 : r_instret_cnt;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
